// File: rtl/s_axis_cc_adapt_x4_pkg.sv
// Shared PCIe adapter definitions: legacy 3-DW TLP header field offsets,
// UltraScale+ completer-completion descriptor offsets and completion type codes.
package s_axis_cc_adapt_x4_pkg;

    // Legacy header fields, as bit offsets within a 128-bit beat (DW0 in [31:0])
    localparam int LEG_LEN_LSB    = 0;
    localparam int LEG_ATTR_LSB   = 12;
    localparam int LEG_EP_BIT     = 14;
    localparam int LEG_TC_LSB     = 20;
    localparam int LEG_TYPE_LSB   = 24;
    localparam int LEG_FMT_LSB    = 29;
    localparam int LEG_BC_LSB     = 32;
    localparam int LEG_STATUS_LSB = 45;
    localparam int LEG_CPL_ID_LSB = 48;
    localparam int LEG_LADDR_LSB  = 64;
    localparam int LEG_TAG_LSB    = 72;
    localparam int LEG_REQ_ID_LSB = 80;

    // Completer-completion descriptor fields
    localparam int CC_LADDR_LSB   = 0;
    localparam int CC_AT_LSB      = 8;
    localparam int CC_BC_LSB      = 16;
    localparam int CC_LOCKED_BIT  = 29;
    localparam int CC_DWCNT_LSB   = 32;
    localparam int CC_STATUS_LSB  = 43;
    localparam int CC_POISON_BIT  = 46;
    localparam int CC_REQ_ID_LSB  = 48;
    localparam int CC_TAG_LSB     = 64;
    localparam int CC_CPL_ID_LSB  = 72;
    localparam int CC_TC_LSB      = 89;
    localparam int CC_ATTR_LSB    = 92;

    typedef enum logic [7:0] {
        FT_CPL     = 8'h0A,
        FT_CPLD    = 8'h4A,
        FT_CPL_LK  = 8'h0B,
        FT_CPLD_LK = 8'h4B
    } cpl_fmt_type_e;

    localparam logic [4:0] TYPE_LOCKED = 5'b01011;

    function automatic logic [2:0] dw_popcount(input logic [3:0] k);
        return {2'b00, k[0]} + {2'b00, k[1]} + {2'b00, k[2]} + {2'b00, k[3]};
    endfunction

endpackage

// File: rtl/pcie_axis_skid.sv
// Generic 2-entry AXI-stream register slice: an output register plus one spare
// entry, with a registered upstream ready.
module pcie_axis_skid #(
    parameter int WIDTH = 166
) (
    input  logic             user_clk,
    input  logic             user_reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             ready_q, out_valid_q, spare_valid_q;
    logic             out_valid_n, spare_valid_n, accept;
    logic [WIDTH-1:0] out_data_q, spare_data_q, out_data_n, spare_data_n;

    // Spare entry is only ever filled while the output register is stalled
    always_comb begin
        out_valid_n   = out_valid_q;
        out_data_n    = out_data_q;
        spare_valid_n = spare_valid_q;
        spare_data_n  = spare_data_q;
        accept        = in_valid && ready_q;
        if (!out_valid_q || out_ready) begin
            if (spare_valid_q) begin
                out_valid_n   = 1'b1;
                out_data_n    = spare_data_q;
                spare_valid_n = 1'b0;
            end else if (accept) begin
                out_valid_n = 1'b1;
                out_data_n  = in_data;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            spare_valid_n = 1'b1;
            spare_data_n  = in_data;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            ready_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            spare_valid_q <= 1'b0;
            out_data_q    <= '0;
            spare_data_q  <= '0;
        end else begin
            ready_q       <= !spare_valid_n;
            out_valid_q   <= out_valid_n;
            spare_valid_q <= spare_valid_n;
            out_data_q    <= out_data_n;
            spare_data_q  <= spare_data_n;
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/s_axis_cc_adapt_x4.sv
// Legacy 128-bit completion TLP to UltraScale+ s_axis_cc adapter: rewrites the
// header beat into a CC descriptor, checks the payload length, and skid-buffers the output.
module s_axis_cc_adapt_x4
    import s_axis_cc_adapt_x4_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  user_clk,
    input  logic                  user_reset,
    input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
    input  logic                  s_axis_cc_tlast,
    input  logic [3:0]            s_axis_cc_tuser,
    input  logic                  s_axis_cc_tvalid,
    output logic [3:0]            s_axis_cc_tready,
    output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
    output logic [3:0]            s_axis_cc_tkeep_a,
    output logic                  s_axis_cc_tlast_a,
    output logic [32:0]           s_axis_cc_tuser_a,
    output logic                  s_axis_cc_tvalid_a,
    input  logic [3:0]            s_axis_cc_tready_a
);

    localparam int PAYLOAD_W = DATA_WIDTH + 4 + 1 + 33;

    logic                  in_pkt, ready, accept, overrun, mismatch, discontinue;
    logic [3:0]            keep_a;
    logic [2:0]            keep_pop;
    logic [9:0]            len;
    logic [12:0]           byte_count;
    logic [10:0]           remaining, remaining_next, dword_count, base_count, data_dw;
    logic [DATA_WIDTH-1:0] hdr_data, beat_data;
    logic [PAYLOAD_W-1:0]  in_payload, out_payload;
    logic                  unused_inputs;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            keep_a[i] = s_axis_cc_tkeep[4*i];
        end
    end

    assign keep_pop    = dw_popcount(keep_a);
    assign len         = s_axis_cc_tdata[LEG_LEN_LSB +: 10];
    assign dword_count = !s_axis_cc_tdata[LEG_FMT_LSB+1] ? 11'd0 :
                         (len == 10'd0) ? 11'd1024 : {1'b0, len};
    assign byte_count  = (s_axis_cc_tdata[LEG_BC_LSB +: 12] == 12'd0) ? 13'd4096 :
                         {1'b0, s_axis_cc_tdata[LEG_BC_LSB +: 12]};

    always_comb begin
        hdr_data                        = '0;
        hdr_data[CC_LADDR_LSB +: 7]     = s_axis_cc_tdata[LEG_LADDR_LSB +: 7];
        hdr_data[CC_AT_LSB +: 2]        = 2'b00;
        hdr_data[CC_BC_LSB +: 13]       = byte_count;
        hdr_data[CC_LOCKED_BIT]         = (s_axis_cc_tdata[LEG_TYPE_LSB +: 5] == TYPE_LOCKED);
        hdr_data[CC_DWCNT_LSB +: 11]    = dword_count;
        hdr_data[CC_STATUS_LSB +: 3]    = s_axis_cc_tdata[LEG_STATUS_LSB +: 3];
        hdr_data[CC_POISON_BIT]         = s_axis_cc_tdata[LEG_EP_BIT];
        hdr_data[CC_REQ_ID_LSB +: 16]   = s_axis_cc_tdata[LEG_REQ_ID_LSB +: 16];
        hdr_data[CC_TAG_LSB +: 8]       = s_axis_cc_tdata[LEG_TAG_LSB +: 8];
        hdr_data[CC_CPL_ID_LSB +: 16]   = s_axis_cc_tdata[LEG_CPL_ID_LSB +: 16];
        hdr_data[CC_TC_LSB +: 3]        = s_axis_cc_tdata[LEG_TC_LSB +: 3];
        hdr_data[CC_ATTR_LSB +: 3]      = {1'b0, s_axis_cc_tdata[LEG_ATTR_LSB +: 2]};
        hdr_data[DATA_WIDTH-1:96]       = s_axis_cc_tdata[DATA_WIDTH-1:96];
    end

    // The header beat carries three header DWs, so only keep beyond those counts as payload
    always_comb begin
        if (in_pkt) begin
            base_count = remaining;
            data_dw    = {8'd0, keep_pop};
        end else begin
            base_count = dword_count;
            data_dw    = (keep_pop > 3'd3) ? {8'd0, keep_pop - 3'd3} : 11'd0;
        end
        overrun        = data_dw > base_count;
        remaining_next = overrun ? 11'd0 : base_count - data_dw;
        mismatch       = overrun || (remaining_next != 11'd0);
    end

    assign discontinue = s_axis_cc_tuser[3] | (s_axis_cc_tlast & mismatch);
    assign beat_data   = in_pkt ? s_axis_cc_tdata : hdr_data;
    assign in_payload  = {beat_data, keep_a, s_axis_cc_tlast, 32'd0, discontinue};
    assign accept      = s_axis_cc_tvalid & ready;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            in_pkt    <= 1'b0;
            remaining <= 11'd0;
        end else if (accept) begin
            in_pkt    <= !s_axis_cc_tlast;
            remaining <= remaining_next;
        end
    end

    pcie_axis_skid #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .user_clk  (user_clk),
        .user_reset(user_reset),
        .in_data   (in_payload),
        .in_valid  (s_axis_cc_tvalid),
        .in_ready  (ready),
        .out_data  (out_payload),
        .out_valid (s_axis_cc_tvalid_a),
        .out_ready (s_axis_cc_tready_a[0])
    );

    assign {s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, s_axis_cc_tuser_a} = out_payload;
    assign s_axis_cc_tready = {4{ready}};

    assign unused_inputs = ^{s_axis_cc_tuser[2:0], s_axis_cc_tready_a[3:1],
                             s_axis_cc_tkeep[15:13], s_axis_cc_tkeep[11:9],
                             s_axis_cc_tkeep[7:5], s_axis_cc_tkeep[3:1]};

endmodule

// File: tb/tb_s_axis_cc_adapt_x4.sv
// Scoreboard bench for s_axis_cc_adapt_x4: directed completion TLPs with
// hand-computed CC descriptors, backpressure, length mismatch and mid-packet reset.
module tb_s_axis_cc_adapt_x4;

    logic         user_clk = 1'b0;
    logic         user_reset = 1'b1;
    logic [127:0] s_axis_cc_tdata;
    logic [15:0]  s_axis_cc_tkeep;
    logic         s_axis_cc_tlast;
    logic [3:0]   s_axis_cc_tuser;
    logic         s_axis_cc_tvalid;
    logic [3:0]   s_axis_cc_tready;
    logic [127:0] s_axis_cc_tdata_a;
    logic [3:0]   s_axis_cc_tkeep_a;
    logic         s_axis_cc_tlast_a;
    logic [32:0]  s_axis_cc_tuser_a;
    logic         s_axis_cc_tvalid_a;
    logic [3:0]   s_axis_cc_tready_a;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
        logic         disc;
    } beat_t;

    beat_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beatNum = 0;

    always #5 user_clk = ~user_clk;

    s_axis_cc_adapt_x4 #(
        .DATA_WIDTH(128),
        .KEEP_WIDTH(16)
    ) dut (
        .user_clk          (user_clk),
        .user_reset        (user_reset),
        .s_axis_cc_tdata   (s_axis_cc_tdata),
        .s_axis_cc_tkeep   (s_axis_cc_tkeep),
        .s_axis_cc_tlast   (s_axis_cc_tlast),
        .s_axis_cc_tuser   (s_axis_cc_tuser),
        .s_axis_cc_tvalid  (s_axis_cc_tvalid),
        .s_axis_cc_tready  (s_axis_cc_tready),
        .s_axis_cc_tdata_a (s_axis_cc_tdata_a),
        .s_axis_cc_tkeep_a (s_axis_cc_tkeep_a),
        .s_axis_cc_tlast_a (s_axis_cc_tlast_a),
        .s_axis_cc_tuser_a (s_axis_cc_tuser_a),
        .s_axis_cc_tvalid_a(s_axis_cc_tvalid_a),
        .s_axis_cc_tready_a(s_axis_cc_tready_a)
    );

    task automatic checkValue(input string name, input logic [167:0] actual, input logic [167:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        beat_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got data %0h, expected no beat", s_axis_cc_tdata_a);
            return;
        end
        e = sb_q.pop_front();
        beatNum++;
        checkValue($sformatf("beat%0d", beatNum),
                   {s_axis_cc_tuser_a, s_axis_cc_tlast_a, s_axis_cc_tkeep_a, s_axis_cc_tdata_a},
                   {32'd0, e.disc, e.last, e.keep, e.data});
    endtask

    task automatic setReady(input logic r);
        s_axis_cc_tready_a = {~r, ~r, ~r, r};
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic [15:0] keep, input logic last,
                                 input logic [3:0] user, input logic [127:0] expData,
                                 input logic [3:0] expKeep, input logic expDisc);
        beat_t b;
        logic  seen;
        int    waitCycles;
        b.data = expData;
        b.keep = expKeep;
        b.last = last;
        b.disc = expDisc;
        sb_q.push_back(b);
        s_axis_cc_tdata  = data;
        s_axis_cc_tkeep  = keep;
        s_axis_cc_tlast  = last;
        s_axis_cc_tuser  = user;
        s_axis_cc_tvalid = 1'b1;
        seen = 1'b0;
        waitCycles = 0;
        while (!seen && waitCycles < 200) begin
            @(negedge user_clk);
            seen = s_axis_cc_tready[0];
            @(posedge user_clk);
            waitCycles++;
        end
        #1;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no ready in %0d cycles, expected ready", waitCycles);
        end
    endtask

    task automatic idleCycles(input int n);
        s_axis_cc_tvalid = 1'b0;
        s_axis_cc_tlast  = 1'b0;
        s_axis_cc_tuser  = 4'h0;
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    // Scoreboard monitor: pops on every handshake and checks hold-stability under stall
    initial begin : monitor
        logic         stalled;
        logic [166:0] snap, cur;
        stalled = 1'b0;
        snap    = '0;
        forever begin
            @(negedge user_clk);
            cur = {s_axis_cc_tvalid_a, s_axis_cc_tuser_a, s_axis_cc_tlast_a, s_axis_cc_tkeep_a, s_axis_cc_tdata_a};
            if (user_reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) checkValue("hold_stable", cur, snap);
                if (s_axis_cc_tvalid_a && s_axis_cc_tready_a[0]) checkOutput();
                stalled = s_axis_cc_tvalid_a && !s_axis_cc_tready_a[0];
                snap = cur;
            end
        end
    end

    initial begin : stimulus
        logic [31:0] w;
        s_axis_cc_tdata  = '0;
        s_axis_cc_tkeep  = '0;
        s_axis_cc_tlast  = 1'b0;
        s_axis_cc_tuser  = 4'h0;
        s_axis_cc_tvalid = 1'b0;
        setReady(1'b1);
        user_reset = 1'b1;

        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        checkValue("rst_tvalid_a", s_axis_cc_tvalid_a, 0);
        checkValue("rst_outputs", {s_axis_cc_tuser_a, s_axis_cc_tlast_a, s_axis_cc_tkeep_a, s_axis_cc_tdata_a}, 0);
        checkValue("rst_tready", s_axis_cc_tready, 4'h0);
        @(posedge user_clk);
        #1 user_reset = 1'b0;
        @(negedge user_clk);
        checkValue("rst_release_tready_low", s_axis_cc_tready, 4'h0);
        @(negedge user_clk);
        checkValue("rst_release_tready_high", s_axis_cc_tready, 4'hF);
        @(posedge user_clk);
        #1;

        // CplD len=1, bc=4; tuser[2:0] set but ignored
        applyStimulus(128'hDEADBEEF_01002A10_02000004_4A000001, 16'hFFFF, 1'b1, 4'h7,
                      128'hDEADBEEF_0002002A_01000001_00040010, 4'hF, 1'b0);
        // Cpl, UR status, poisoned, TC=3, attr=2'b10, no data
        applyStimulus(128'h11111111_ABCD0585_12342004_0A306000, 16'h0FFF, 1'b1, 4'h0,
                      128'h11111111_26123405_ABCD4800_00040005, 4'h7, 1'b0);
        // CplDLk len=9 across 3 beats, user discontinue on the middle beat
        applyStimulus(128'hA0A0A0A0_04007F40_03000024_4B000009, 16'hFFFF, 1'b0, 4'h0,
                      128'hA0A0A0A0_0003007F_04000009_20240040, 4'hF, 1'b0);
        applyStimulus(128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, 1'b0, 4'h8,
                      128'h01234567_89ABCDEF_FEDCBA98_76543210, 4'hF, 1'b1);
        applyStimulus(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 1'b1, 4'h0,
                      128'h0F0E0D0C_0B0A0908_07060504_03020100, 4'hF, 1'b0);
        // CplD len=0 (1024 DW), bc=0 (4096 bytes): 1 + 255*4 + 3 DW of payload
        applyStimulus(128'hCAFEF00D_06000100_05000000_4A000000, 16'hFFFF, 1'b0, 4'h0,
                      128'hCAFEF00D_00050001_06000400_10000000, 4'hF, 1'b0);
        for (int i = 0; i < 255; i++) begin
            w = 32'(i) * 32'd4;
            applyStimulus({w + 32'd3, w + 32'd2, w + 32'd1, w}, 16'hFFFF, 1'b0, 4'h0,
                          {w + 32'd3, w + 32'd2, w + 32'd1, w}, 4'hF, 1'b0);
        end
        applyStimulus(128'h00000000_BBBBBBBB_AAAAAAAA_99999999, 16'h0FFF, 1'b1, 4'h0,
                      128'h00000000_BBBBBBBB_AAAAAAAA_99999999, 4'h7, 1'b0);
        idleCycles(3);

        // Backpressure: IP stalls 3 cycles while a 4-beat CplD len=12 streams in
        fork
            begin
                applyStimulus(128'h12121212_0A004408_09000030_4A00000C, 16'hFFFF, 1'b0, 4'h0,
                              128'h12121212_00090044_0A00000C_00300008, 4'hF, 1'b0);
                applyStimulus(128'h24242424_23232323_22222222_21212121, 16'hFFFF, 1'b0, 4'h0,
                              128'h24242424_23232323_22222222_21212121, 4'hF, 1'b0);
                applyStimulus(128'h34343434_33333333_32323232_31313131, 16'hFFFF, 1'b0, 4'h0,
                              128'h34343434_33333333_32323232_31313131, 4'hF, 1'b0);
                applyStimulus(128'h44444444_43434343_42424242_41414141, 16'h0FFF, 1'b1, 4'h0,
                              128'h44444444_43434343_42424242_41414141, 4'h7, 1'b0);
                s_axis_cc_tvalid = 1'b0;
            end
            begin
                @(posedge user_clk);
                #2 setReady(1'b0);
                @(negedge user_clk);
                checkValue("bp_ready_at_stall", s_axis_cc_tready, 4'hF);
                checkValue("bp_valid_at_stall", s_axis_cc_tvalid_a, 1);
                @(negedge user_clk);
                checkValue("bp_ready_dropped", s_axis_cc_tready, 4'h0);
                @(posedge user_clk);
                @(posedge user_clk);
                #2 setReady(1'b1);
            end
        join
        idleCycles(4);

        // Length mismatch: len=8 but only 5 payload DW before tlast; next TLP is clean
        applyStimulus(128'h55555555_08003300_07000020_4A000008, 16'hFFFF, 1'b0, 4'h0,
                      128'h55555555_00070033_08000008_00200000, 4'hF, 1'b0);
        applyStimulus(128'h99999999_88888888_77777777_66666666, 16'hFFFF, 1'b1, 4'h0,
                      128'h99999999_88888888_77777777_66666666, 4'hF, 1'b1);
        applyStimulus(128'hDEADBEEF_01002A10_02000004_4A000001, 16'hFFFF, 1'b1, 4'h0,
                      128'hDEADBEEF_0002002A_01000001_00040010, 4'hF, 1'b0);
        idleCycles(4);

        // Reset mid-packet with both buffer entries occupied
        setReady(1'b0);
        applyStimulus(128'h77777777_0C000000_0B000010_4A000004, 16'hFFFF, 1'b0, 4'h0,
                      128'h0, 4'h0, 1'b0);
        applyStimulus(128'h01010101_02020202_03030303_04040404, 16'hFFFF, 1'b0, 4'h0,
                      128'h0, 4'h0, 1'b0);
        s_axis_cc_tvalid = 1'b0;
        @(negedge user_clk);
        checkValue("pre_reset_valid", s_axis_cc_tvalid_a, 1);
        checkValue("pre_reset_ready_full", s_axis_cc_tready, 4'h0);
        @(posedge user_clk);
        #1 user_reset = 1'b1;
        @(negedge user_clk);
        @(negedge user_clk);
        checkValue("mid_reset_valid_cleared", s_axis_cc_tvalid_a, 0);
        sb_q.delete();
        @(posedge user_clk);
        #1 user_reset = 1'b0;
        setReady(1'b1);
        @(negedge user_clk);
        @(negedge user_clk);
        checkValue("post_reset_ready", s_axis_cc_tready, 4'hF);
        @(posedge user_clk);
        #1;
        applyStimulus(128'hDEADBEEF_01002A10_02000004_4A000001, 16'hFFFF, 1'b1, 4'h0,
                      128'hDEADBEEF_0002002A_01000001_00040010, 4'hF, 1'b0);
        idleCycles(2);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge user_clk);
        checkValue("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
